// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: stall/flush/freeze sequencing,
// EX-stage forwarding selects, perf counters and a sticky memory-timeout flag. Optional: HAZ_FORWARD_EN.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_MemRead,
  input  logic             ex_RegWrite,
  input  logic [4:0]       ex_rd,
  input  logic             mem_RegWrite,
  input  logic [4:0]       mem_rd,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             timeout_err
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        ex_match;
  logic        mem_match;
  logic        data_hazard;

  // A producer "matches" the ID instruction when it writes a register ID reads; $0 never does.
  assign ex_match  = (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_match = (mem_rd != 5'd0) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

`ifdef HAZ_FORWARD_EN
  logic fwd_unused;
  assign fwd_unused  = ex_RegWrite ^ mem_match;
  assign data_hazard = ex_MemRead && ex_match;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_rs))     fwd_a = 2'b10;
    else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs))   fwd_a = 2'b01;
    if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_rt))     fwd_b = 2'b10;
    else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_rt))   fwd_b = 2'b01;
  end
`else
  // Without forwarding the regfile writes before it is read, so WB never needs a stall.
  logic fwd_unused;
  assign fwd_unused  = ^{ex_rs, ex_rt, wb_RegWrite, wb_rd, ex_MemRead};
  assign data_hazard = (ex_RegWrite && ex_match) || (mem_RegWrite && mem_match);
  assign fwd_a       = 2'b00;
  assign fwd_b       = 2'b00;
`endif

  // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned (no latch).
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (data_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  // NOTE: all state here is flop-based, so every register is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= 16'd0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEMWAIT;
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT) timeout_err <= 1'b1;
          end else begin
            wait_cnt <= 16'd0;
          end
        end
        MEMWAIT: begin
          if (!mem_busy) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT) timeout_err <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 16'd0;
        end
      endcase
      if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
      if (ifid_flush && (flush_count != '1))  flush_count  <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes model predictions, a negedge monitor compares.
module tb_hazard_ctrl;

  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs, ex_rt;
    logic       ex_MemRead, ex_RegWrite;
    logic [4:0] ex_rd;
    logic       mem_RegWrite;
    logic [4:0] mem_rd;
    logic       wb_RegWrite;
    logic [4:0] wb_rd;
    logic       br, busy, rst_n;
  } stim_t;

  typedef struct packed {
    logic       pc_write, ifid_write, idex_hold, exmem_hold, ifid_flush, idex_bubble;
    logic [1:0] fwd_a, fwd_b;
    int         stall, flush;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rt, ex_MemRead, ex_RegWrite, mem_RegWrite, wb_RegWrite;
  logic ex_branch_taken, mem_busy;
  logic pc_write, ifid_write, idex_hold, exmem_hold, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic timeout_err;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
    .ex_rd(ex_rd), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: plain integers describing what has happened so far.
  int   busy_run_m = 0;
  int   stall_m    = 0;
  int   flush_m    = 0;
  bit   err_m      = 0;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, want);
    end
  endtask

  function automatic bit reads(input stim_t s, input logic [4:0] r);
    return (r != 0) && ((r == s.id_rs) || (s.id_uses_rt && r == s.id_rt));
  endfunction

  function automatic logic [1:0] fwd_src(input stim_t s, input logic [4:0] src);
`ifdef HAZ_FORWARD_EN
    if (src != 0 && s.mem_RegWrite && s.mem_rd == src) return 2'b10;
    if (src != 0 && s.wb_RegWrite && s.wb_rd == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit   hazard;
`ifdef HAZ_FORWARD_EN
    hazard = s.ex_MemRead && reads(s, s.ex_rd);
`else
    hazard = (s.ex_RegWrite && reads(s, s.ex_rd)) || (s.mem_RegWrite && reads(s, s.mem_rd));
`endif
    e = '0;
    if (s.busy)         {e.pc_write, e.ifid_write, e.idex_hold, e.exmem_hold} = 4'b0011;
    else if (s.br)      {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble} = 4'b1111;
    else if (hazard)    {e.pc_write, e.ifid_write, e.idex_bubble} = 3'b001;
    else                {e.pc_write, e.ifid_write} = 2'b11;
    e.fwd_a = fwd_src(s, s.ex_rs);
    e.fwd_b = fwd_src(s, s.ex_rt);
    e.stall = stall_m;
    e.flush = flush_m;
    e.err   = err_m;
    return e;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    rst_n = s.rst_n; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
    ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_MemRead = s.ex_MemRead; ex_RegWrite = s.ex_RegWrite;
    ex_rd = s.ex_rd; mem_RegWrite = s.mem_RegWrite; mem_rd = s.mem_rd;
    wb_RegWrite = s.wb_RegWrite; wb_rd = s.wb_rd; ex_branch_taken = s.br; mem_busy = s.busy;
    if (!s.rst_n) begin
      busy_run_m = 0; stall_m = 0; flush_m = 0; err_m = 0;
    end
    e = predict(s);
    exp_q.push_back(e);
    if (s.rst_n) begin
      busy_run_m = s.busy ? busy_run_m + 1 : 0;
      if (busy_run_m >= MEM_TIMEOUT) err_m = 1;
      if (!e.pc_write && stall_m < CNT_MAX) stall_m++;
      if (e.ifid_flush && flush_m < CNT_MAX) flush_m++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_write",     int'(pc_write),     int'(e.pc_write));
      check("ifid_write",   int'(ifid_write),   int'(e.ifid_write));
      check("idex_hold",    int'(idex_hold),    int'(e.idex_hold));
      check("exmem_hold",   int'(exmem_hold),   int'(e.exmem_hold));
      check("ifid_flush",   int'(ifid_flush),   int'(e.ifid_flush));
      check("idex_bubble",  int'(idex_bubble),  int'(e.idex_bubble));
      check("fwd_a",        int'(fwd_a),        int'(e.fwd_a));
      check("fwd_b",        int'(fwd_b),        int'(e.fwd_b));
      check("stall_cycles", int'(stall_cycles), e.stall);
      check("flush_count",  int'(flush_count),  e.flush);
      check("timeout_err",  int'(timeout_err),  int'(e.err));
    end
  end

  initial begin
    stim_t s;
    int    burst;
    s = idle();
    s.rst_n = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step(s);

    // Load-use: lw $8 in EX, ID reads $8.
    s = idle(); s.ex_MemRead = 1; s.ex_RegWrite = 1; s.ex_rd = 8; s.id_rs = 8;
    step(s);
    s = idle(); step(s);

    // Forwarding priority and $0 suppression.
    s = idle(); s.id_rs = 1; s.mem_RegWrite = 1; s.mem_rd = 5; s.wb_RegWrite = 1; s.wb_rd = 5;
    s.ex_rs = 5; step(s);
    s = idle(); s.wb_RegWrite = 1; s.wb_rd = 0; s.ex_rt = 0; s.ex_rs = 0; step(s);
    s = idle(); s.wb_RegWrite = 1; s.wb_rd = 9; s.ex_rt = 9; step(s);

    // Taken branch beats a concurrent load-use.
    s = idle(); s.br = 1; s.ex_MemRead = 1; s.ex_RegWrite = 1; s.ex_rd = 4; s.id_rs = 4;
    step(s);

    // Long freeze to timeout, release, then a reset mid-wait.
    s = idle(); s.busy = 1; s.br = 1;
    repeat (MEM_TIMEOUT + 2) step(s);
    s = idle(); step(s);
    s = idle(); s.busy = 1;
    repeat (20) step(s);
    s.rst_n = 1'b0; step(s);
    s.rst_n = 1'b1; repeat (5) step(s);
    s = idle(); step(s);

    // add $3 in MEM, ID reads $3 through rt, with and without id_uses_rt.
    s = idle(); s.mem_RegWrite = 1; s.mem_rd = 3; s.id_rt = 3; s.id_uses_rt = 1; step(s);
    s.id_uses_rt = 0; step(s);

    // Drive the stall counter past all-ones.
    s = idle(); s.ex_MemRead = 1; s.ex_RegWrite = 1; s.ex_rd = 7; s.id_rt = 7; s.id_uses_rt = 1;
    repeat (CNT_MAX + 10) step(s);

    // Randomised traffic with occasional memory bursts and resets.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.id_rs = 5'($urandom_range(0, 7)); s.id_rt = 5'($urandom_range(0, 7));
      s.id_uses_rt = 1'($urandom); s.ex_rs = 5'($urandom_range(0, 7));
      s.ex_rt = 5'($urandom_range(0, 7)); s.ex_MemRead = 1'($urandom);
      s.ex_RegWrite = 1'($urandom); s.ex_rd = 5'($urandom_range(0, 7));
      s.mem_RegWrite = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 7));
      s.wb_RegWrite = 1'($urandom); s.wb_rd = 5'($urandom_range(0, 7));
      s.br = ($urandom_range(0, 5) == 0);
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 80);
      if (burst > 0) begin
        s.busy = 1'b1;
        burst--;
      end
      s.rst_n = ($urandom_range(0, 299) != 0);
      step(s);
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions never compared", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
